// File: rtl/mpu_pkg.sv
// Shared MPU definitions: element format, matrix geometry, operation codes
// and the request structs passed between the load controller and the register file.
package mpu_pkg;

   localparam int FP               = 32;
   localparam int M                = 4;
   localparam int N                = 4;
   localparam int MBITS            = $clog2(M);
   localparam int NBITS            = $clog2(N);
   localparam int MATRIX_REGISTERS = 4;
   localparam int MATRIX_REG_SIZE  = $clog2(MATRIX_REGISTERS);

   typedef logic [FP-1:0] float_sp;

   typedef enum logic [2:0] {
      NOP,
      LOAD,
      STORE,
      MUL,
      ADD,
      SUB
   } mpu_operation_t;

   // Element write; clr wipes the whole slot before the element lands
   typedef struct packed {
      logic                       en;
      logic                       clr;
      logic [MATRIX_REG_SIZE-1:0] addr;
      logic [MBITS-1:0]           i;
      logic [NBITS-1:0]           j;
      float_sp                    data;
   } reg_wr_req_t;

   // Stored-size update for one slot
   typedef struct packed {
      logic                       en;
      logic [MATRIX_REG_SIZE-1:0] addr;
      logic [MBITS:0]             m;
      logic [NBITS:0]             n;
   } size_wr_req_t;

   // Store-side element read
   typedef struct packed {
      logic                       en;
      logic [MATRIX_REG_SIZE-1:0] addr;
      logic [MBITS-1:0]           i;
      logic [NBITS-1:0]           j;
   } reg_rd_req_t;

   // A matrix shape is loadable when both dimensions are non-zero and fit the slot
   function automatic logic size_ok(input logic [MBITS:0] m, input logic [NBITS:0] n);
      return (m != '0) && (n != '0) &&
             (m <= (MBITS+1)'(M)) && (n <= (NBITS+1)'(N));
   endfunction

endpackage

// File: rtl/matrix_reg_array.sv
// Matrix register file: MATRIX_REGISTERS slots of M x N FP32 elements,
// one element write port, a per-slot size table and a registered read port.
module matrix_reg_array
   import mpu_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  reg_wr_req_t                wr,
   input  size_wr_req_t               sz,
   input  reg_rd_req_t                rd,
   input  logic [MATRIX_REG_SIZE-1:0] size_addr,
   output float_sp                    rd_data,
   output logic                       rd_complete,
   output logic [MBITS:0]             m_size,
   output logic [NBITS:0]             n_size
);

   float_sp    [MATRIX_REGISTERS-1:0][M-1:0][N-1:0] mem;
   logic [MATRIX_REGISTERS-1:0][MBITS:0]            m_mem;
   logic [MATRIX_REGISTERS-1:0][NBITS:0]            n_mem;

   logic           rd_in_range;
   logic           rd_is_last;
   logic [MBITS:0] rd_last_i;
   logic [NBITS:0] rd_last_j;

   // Element storage: clearing and the first element of a load share one edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem <= '0;
      end else if (wr.en) begin
         if (wr.clr) mem[wr.addr] <= '0;
         mem[wr.addr][wr.i][wr.j] <= wr.data;
      end
   end

   // Stored shape per slot, updated only when a load finishes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mem <= '0;
         n_mem <= '0;
      end else if (sz.en) begin
         m_mem[sz.addr] <= sz.m;
         n_mem[sz.addr] <= sz.n;
      end
   end

   // Range and last-element decode for the read request
   always_comb begin
      rd_last_i   = m_mem[rd.addr] - (MBITS+1)'(1);
      rd_last_j   = n_mem[rd.addr] - (NBITS+1)'(1);
      rd_in_range = ({1'b0, rd.i} < (MBITS+1)'(M)) && ({1'b0, rd.j} < (NBITS+1)'(N));
      rd_is_last  = rd_in_range && ({1'b0, rd.i} == rd_last_i) && ({1'b0, rd.j} == rd_last_j);
   end

   // Registered read: data holds between requests, complete only flags the reply cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data     <= '0;
         rd_complete <= 1'b0;
      end else begin
         rd_complete <= 1'b0;
         if (rd.en) begin
            rd_data     <= rd_in_range ? mem[rd.addr][rd.i][rd.j] : '0;
            rd_complete <= rd_is_last;
         end
      end
   end

   assign m_size = m_mem[size_addr];
   assign n_size = n_mem[size_addr];

endmodule

// File: rtl/mpu_load_regfile.sv
// MPU matrix load path: streams a row-major FP32 matrix from memory into a
// register-file slot and serves element reads to the store unit.
module mpu_load_regfile
   import mpu_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_en_in,
   input  logic [FP-1:0]              mem_element_in,
   input  logic [MBITS:0]             mem_m_size_in,
   input  logic [NBITS:0]             mem_n_size_in,
   input  logic [MATRIX_REG_SIZE-1:0] mem_load_addr_in,
   output logic                       mem_load_ack_out,
   output logic                       mem_load_error_out,
   output logic                       load_busy_out,
   input  logic                       reg_store_en_in,
   input  logic [MATRIX_REG_SIZE-1:0] reg_store_addr_in,
   input  logic [MBITS-1:0]           reg_i_store_loc_in,
   input  logic [NBITS-1:0]           reg_j_store_loc_in,
   output logic [FP-1:0]              reg_store_element_out,
   output logic                       reg_store_complete_out,
   output logic [MBITS:0]             reg_m_size_out,
   output logic [NBITS:0]             reg_n_size_out
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE
   } state_t;

   state_t                     state;
   logic [MBITS:0]             m_q;
   logic [NBITS:0]             n_q;
   logic [MATRIX_REG_SIZE-1:0] addr_q;
   logic [MBITS-1:0]           i_q;
   logic [NBITS-1:0]           j_q;
   logic                       ack_q;
   logic                       err_q;
   logic                       busy_q;

   logic                       start_ok;
   logic                       j_last;
   logic                       elem_last;
   reg_wr_req_t                wr;
   size_wr_req_t               sz;
   reg_rd_req_t                rd;

   assign start_ok  = size_ok(mem_m_size_in, mem_n_size_in);
   assign j_last    = ({1'b0, j_q} == n_q - (NBITS+1)'(1));
   assign elem_last = j_last && ({1'b0, i_q} == m_q - (MBITS+1)'(1));

   // Register-file write strobes: element (0,0) lands on the accepting edge itself
   always_comb begin
      wr = '0;
      sz = '0;
      case (state)
         ST_IDLE: begin
            if (load_en_in && start_ok) begin
               wr.en   = 1'b1;
               wr.clr  = 1'b1;
               wr.addr = mem_load_addr_in;
               wr.data = mem_element_in;
            end
         end
         ST_LOAD: begin
            wr.en   = 1'b1;
            wr.addr = addr_q;
            wr.i    = i_q;
            wr.j    = j_q;
            wr.data = mem_element_in;
         end
         ST_DONE: begin
            sz.en   = 1'b1;
            sz.addr = addr_q;
            sz.m    = m_q;
            sz.n    = n_q;
         end
         default: ;
      endcase
   end

   // Load controller: size check, row-major index walk, one-cycle ack/error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         m_q    <= '0;
         n_q    <= '0;
         addr_q <= '0;
         i_q    <= '0;
         j_q    <= '0;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_en_in) begin
                  if (!start_ok) begin
                     err_q <= 1'b1;
                  end else begin
                     m_q    <= mem_m_size_in;
                     n_q    <= mem_n_size_in;
                     addr_q <= mem_load_addr_in;
                     if (mem_m_size_in == (MBITS+1)'(1) && mem_n_size_in == (NBITS+1)'(1)) begin
                        state <= ST_DONE;
                     end else begin
                        state  <= ST_LOAD;
                        busy_q <= 1'b1;
                        // (0,0) is already written, so start the walk at the next element
                        if (mem_n_size_in == (NBITS+1)'(1)) begin
                           i_q <= MBITS'(1);
                           j_q <= '0;
                        end else begin
                           i_q <= '0;
                           j_q <= NBITS'(1);
                        end
                     end
                  end
               end
            end
            ST_LOAD: begin
               if (elem_last) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
               end else if (j_last) begin
                  j_q <= '0;
                  i_q <= i_q + MBITS'(1);
               end else begin
                  j_q <= j_q + NBITS'(1);
               end
            end
            ST_DONE: begin
               ack_q <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rd.en   = reg_store_en_in;
   assign rd.addr = reg_store_addr_in;
   assign rd.i    = reg_i_store_loc_in;
   assign rd.j    = reg_j_store_loc_in;

   matrix_reg_array u_regs (
      .clk         (clk),
      .rst         (rst),
      .wr          (wr),
      .sz          (sz),
      .rd          (rd),
      .size_addr   (reg_store_addr_in),
      .rd_data     (reg_store_element_out),
      .rd_complete (reg_store_complete_out),
      .m_size      (reg_m_size_out),
      .n_size      (reg_n_size_out)
   );

   assign mem_load_ack_out   = ack_q;
   assign mem_load_error_out = err_q;
   assign load_busy_out      = busy_q;

endmodule

// File: tb/tb_mpu_load_regfile.sv
// Directed-plus-random bench for mpu_load_regfile against a slot/shape reference model.
module tb_mpu_load_regfile;
   import mpu_pkg::*;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       load_en_in;
   logic [FP-1:0]              mem_element_in;
   logic [MBITS:0]             mem_m_size_in;
   logic [NBITS:0]             mem_n_size_in;
   logic [MATRIX_REG_SIZE-1:0] mem_load_addr_in;
   logic                       mem_load_ack_out;
   logic                       mem_load_error_out;
   logic                       load_busy_out;
   logic                       reg_store_en_in;
   logic [MATRIX_REG_SIZE-1:0] reg_store_addr_in;
   logic [MBITS-1:0]           reg_i_store_loc_in;
   logic [NBITS-1:0]           reg_j_store_loc_in;
   logic [FP-1:0]              reg_store_element_out;
   logic                       reg_store_complete_out;
   logic [MBITS:0]             reg_m_size_out;
   logic [NBITS:0]             reg_n_size_out;

   mpu_load_regfile dut (
      .clk                    (clk),
      .rst                    (rst),
      .load_en_in             (load_en_in),
      .mem_element_in         (mem_element_in),
      .mem_m_size_in          (mem_m_size_in),
      .mem_n_size_in          (mem_n_size_in),
      .mem_load_addr_in       (mem_load_addr_in),
      .mem_load_ack_out       (mem_load_ack_out),
      .mem_load_error_out     (mem_load_error_out),
      .load_busy_out          (load_busy_out),
      .reg_store_en_in        (reg_store_en_in),
      .reg_store_addr_in      (reg_store_addr_in),
      .reg_i_store_loc_in     (reg_i_store_loc_in),
      .reg_j_store_loc_in     (reg_j_store_loc_in),
      .reg_store_element_out  (reg_store_element_out),
      .reg_store_complete_out (reg_store_complete_out),
      .reg_m_size_out         (reg_m_size_out),
      .reg_n_size_out         (reg_n_size_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: each slot is a flat row-major M*N array plus its stored shape
   logic [31:0] ref_mem [MATRIX_REGISTERS][M*N];
   int          ref_m   [MATRIX_REGISTERS];
   int          ref_n   [MATRIX_REGISTERS];
   logic [31:0] stim    [M*N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < MATRIX_REGISTERS; s++) begin
         for (int k = 0; k < M*N; k++) ref_mem[s][k] = '0;
         ref_m[s] = 0;
         ref_n[s] = 0;
      end
   endtask

   // Entered and left at #1 after a rising edge
   task automatic do_load(input int a, input int m, input int n, input bit poke);
      int acks = 0;
      int mn   = m * n;
      load_en_in       = 1'b1;
      mem_m_size_in    = 3'(m);
      mem_n_size_in    = 3'(n);
      mem_load_addr_in = 2'(a);
      mem_element_in   = stim[0];
      @(posedge clk); #1;
      load_en_in = 1'b0;
      chk("busy_after_accept", 32'(load_busy_out), 32'(mn > 1));
      chk("ack_at_accept", 32'(mem_load_ack_out), 32'd0);
      for (int c = 1; c <= mn + 1; c++) begin
         mem_element_in = (c < mn) ? stim[c] : $urandom;
         if (poke && c == 1) begin
            load_en_in         = 1'b1;
            mem_m_size_in      = 3'd1;
            mem_n_size_in      = 3'd1;
            mem_load_addr_in   = 2'(a + 1);
            reg_store_en_in    = 1'b1;
            reg_store_addr_in  = 2'(a);
            reg_i_store_loc_in = 2'd0;
            reg_j_store_loc_in = 2'd1;
         end
         @(posedge clk); #1;
         if (poke && c == 1) begin
            load_en_in      = 1'b0;
            reg_store_en_in = 1'b0;
            chk("read_during_write_old", reg_store_element_out, 32'd0);
         end
         acks += int'(mem_load_ack_out);
         chk("ack_timing", 32'(mem_load_ack_out), 32'(c == mn));
         chk("busy_during_load", 32'(load_busy_out), 32'(c < mn - 1));
      end
      chk("ack_count", 32'(acks), 32'd1);
      for (int k = 0; k < M*N; k++) ref_mem[a][k] = '0;
      for (int r = 0; r < m; r++)
         for (int cc = 0; cc < n; cc++) ref_mem[a][r*N + cc] = stim[r*n + cc];
      ref_m[a] = m;
      ref_n[a] = n;
   endtask

   task automatic do_bad(input int a, input int m, input int n);
      load_en_in       = 1'b1;
      mem_m_size_in    = 3'(m);
      mem_n_size_in    = 3'(n);
      mem_load_addr_in = 2'(a);
      mem_element_in   = $urandom;
      @(posedge clk); #1;
      load_en_in = 1'b0;
      chk("err_pulse", 32'(mem_load_error_out), 32'd1);
      chk("err_busy", 32'(load_busy_out), 32'd0);
      @(posedge clk); #1;
      chk("err_one_cycle", 32'(mem_load_error_out), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("err_no_ack", 32'(mem_load_ack_out), 32'd0);
      end
   endtask

   task automatic rd(input int a, input int i, input int j);
      reg_store_en_in    = 1'b1;
      reg_store_addr_in  = 2'(a);
      reg_i_store_loc_in = 2'(i);
      reg_j_store_loc_in = 2'(j);
      #1;
      chk("m_size", 32'(reg_m_size_out), 32'(ref_m[a]));
      chk("n_size", 32'(reg_n_size_out), 32'(ref_n[a]));
      @(posedge clk); #1;
      reg_store_en_in = 1'b0;
      chk($sformatf("rd_data[%0d][%0d][%0d]", a, i, j), reg_store_element_out, ref_mem[a][i*N + j]);
      chk("rd_complete", 32'(reg_store_complete_out),
          32'(ref_m[a] > 0 && i == ref_m[a] - 1 && j == ref_n[a] - 1));
   endtask

   task automatic rd_slot(input int a);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < N; j++) rd(a, i, j);
   endtask

   task automatic rand_stim();
      for (int k = 0; k < M*N; k++) stim[k] = $urandom;
   endtask

   initial begin
      rst                = 1'b1;
      load_en_in         = 1'b0;
      mem_element_in     = '0;
      mem_m_size_in      = '0;
      mem_n_size_in      = '0;
      mem_load_addr_in   = '0;
      reg_store_en_in    = 1'b0;
      reg_store_addr_in  = '0;
      reg_i_store_loc_in = '0;
      reg_j_store_loc_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 32'(mem_load_ack_out), 32'd0);
      chk("rst_err", 32'(mem_load_error_out), 32'd0);
      chk("rst_busy", 32'(load_busy_out), 32'd0);
      chk("rst_data", reg_store_element_out, 32'd0);
      chk("rst_complete", 32'(reg_store_complete_out), 32'd0);
      chk("rst_m_size", 32'(reg_m_size_out), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 2x2 reference values into slot 0
      stim[0] = 32'h3f800000; stim[1] = 32'h424951ec;
      stim[2] = 32'hc0200000; stim[3] = 32'h3e000000;
      do_load(0, 2, 2, 1'b0);
      rd_slot(0);

      // 2x2 of 2.0 into slot 1, slot 0 must be untouched
      for (int k = 0; k < M*N; k++) stim[k] = 32'h40000000;
      do_load(1, 2, 2, 1'b0);
      rd_slot(0);
      rd_slot(1);

      // rejected shapes leave everything alone
      do_bad(0, 0, 2);
      do_bad(0, 5, 2);
      do_bad(2, 2, 0);
      do_bad(2, 3, 5);
      rd_slot(0);

      // read data holds while no read is requested
      rd(0, 1, 0);
      @(posedge clk); #1;
      chk("rd_hold", reg_store_element_out, ref_mem[0][N]);

      // second load_en mid-load is ignored; read-during-write returns old value
      rand_stim();
      do_load(2, 3, 3, 1'b1);
      rd_slot(2);
      rd_slot(3);

      // shape extremes and a shrinking reload that must clear stale elements
      rand_stim(); do_load(3, 1, 1, 1'b0);
      rand_stim(); do_load(1, 4, 4, 1'b0);
      rd_slot(1);
      rand_stim(); do_load(1, 2, 1, 1'b0);
      rd_slot(1);
      rd_slot(3);

      // random shapes and slots
      for (int t = 0; t < 6; t++) begin
         int a = int'($urandom_range(0, 3));
         int m = int'($urandom_range(1, 4));
         int n = int'($urandom_range(1, 4));
         rand_stim();
         do_load(a, m, n, 1'b0);
         rd_slot(a);
      end

      // reset after two of four elements aborts the load
      rd(0, 0, 0);
      rand_stim();
      load_en_in       = 1'b1;
      mem_m_size_in    = 3'd2;
      mem_n_size_in    = 3'd2;
      mem_load_addr_in = 2'd3;
      mem_element_in   = stim[0];
      @(posedge clk); #1;
      load_en_in     = 1'b0;
      mem_element_in = stim[1];
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_ack", 32'(mem_load_ack_out), 32'd0);
      chk("midrst_err", 32'(mem_load_error_out), 32'd0);
      chk("midrst_busy", 32'(load_busy_out), 32'd0);
      chk("midrst_data", reg_store_element_out, 32'd0);
      chk("midrst_complete", 32'(reg_store_complete_out), 32'd0);
      chk("midrst_m_size", 32'(reg_m_size_out), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 5; c++) begin
         mem_element_in = $urandom;
         @(posedge clk); #1;
         chk("postrst_no_ack", 32'(mem_load_ack_out), 32'd0);
      end
      rd_slot(3);
      rd_slot(0);

      rand_stim();
      do_load(3, 2, 2, 1'b0);
      for (int s = 0; s < MATRIX_REGISTERS; s++) rd_slot(s);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mpu_load_regfile.md
Name: mpu_load_regfile

Overview:
Matrix load path of the MPU: a load controller plus the matrix register file.
- Accepts a matrix streamed from memory one FP32 element per cycle, row-major.
- Writes the elements into one of MATRIX_REGISTERS matrix slots.
- Exposes a read (store-side) port so a store unit can read elements back.
- Sits between the memory interface and the MPU datapath/store unit.

Parameters:
- FP, 32, element width (IEEE-754 single).
- M, 4, max rows per matrix.
- N, 4, max columns per matrix.
- MBITS, $clog2(M), row index width.
- NBITS, $clog2(N), column index width.
- MATRIX_REGISTERS, 4, number of matrix slots.
- MATRIX_REG_SIZE, $clog2(MATRIX_REGISTERS), slot address width.

Ports:
Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.

Load side:
- load_en_in  in  1  start-of-load pulse.
- mem_element_in  in  FP  streamed element.
- mem_m_size_in  in  MBITS+1  row count.
- mem_n_size_in  in  NBITS+1  column count.
- mem_load_addr_in  in  MATRIX_REG_SIZE  destination slot.
- mem_load_ack_out  out  1  load-done pulse.
- mem_load_error_out  out  1  bad-size pulse.
- load_busy_out  out  1  load in progress.

Store/read side:
- reg_store_en_in  in  1  read request.
- reg_store_addr_in  in  MATRIX_REG_SIZE  slot to read.
- reg_i_store_loc_in  in  MBITS  row index.
- reg_j_store_loc_in  in  NBITS  column index.
- reg_store_element_out  out  FP  read data.
- reg_store_complete_out  out  1  last element of the slot read.
- reg_m_size_out  out  MBITS+1  stored m of the requested slot (combinational).
- reg_n_size_out  out  NBITS+1  stored n of the requested slot (combinational).

Behaviour:
Reset:
- All slot elements, stored sizes and all outputs go to 0.
- Controller enters IDLE.

Controller states are IDLE, LOAD and DONE.

IDLE:
- On a clock edge with load_en_in=1, latch m, n and addr.
- Size check: if m==0, n==0, m>M or n>N, pulse mem_load_error_out for 1 cycle, perform no write and stay in IDLE.
- Otherwise write mem_element_in to (addr,0,0) on that edge and go to LOAD (or to DONE if m*n==1).

LOAD:
- Each edge writes mem_element_in at the current (i,j).
- Indices advance row-major: j increments; at j==n-1, j wraps to 0 and i increments.
- The write at (m-1,n-1) moves the controller to DONE.
- load_busy_out=1 from the first accepted edge until DONE.

DONE:
- mem_load_ack_out=1 for exactly 1 cycle.
- The slot's stored m and n are updated.
- Return to IDLE.
- Total latency: ack is asserted m*n cycles after the accepting edge.

Other load rules:
- load_en_in is ignored while busy or in DONE.
- Elements outside m x n in the slot are cleared to 0 when the load starts, so the slot never shows stale data.
- Other slots are never modified.

Read port:
- When reg_store_en_in=1 at an edge, reg_store_element_out takes slot[addr][i][j] on the next cycle (registered, 1-cycle latency); otherwise it holds its value.
- reg_store_complete_out=1 in the same cycle as the data when (i,j)==(m-1,n-1) of that slot's stored size; 0 otherwise.
- An out-of-range index (i>=M or j>=N) returns 0.

Simultaneous events and reset:
- Read and load of the same location in one cycle: the read returns the old value.
- Reset mid-load aborts the load; no ack is produced and the partial slot is cleared by reset.

Decomposition:
- Shared package mpu_pkg holds FP, M, N, MBITS, NBITS, MATRIX_REGISTERS, MATRIX_REG_SIZE.
- It also holds the float_sp element typedef and the mpu_operation_t enum (NOP, LOAD, STORE, ...).
- One natural sub-module, matrix_reg_array: storage, write port and registered read port.
- The load FSM and index counters stay in the top.

Test Plan:
- Load 2x2 into slot 0 with stream 3f800000, 424951ec, c0200000, 3e000000 -> ack 4 cycles after the start edge; reads of (0,0), (0,1), (1,0), (1,1) return 1.0, 50.33, -2.5, 0.125; reg_store_complete_out=1 only on (1,1).
- Load 2x2 of all 0x40000000 into slot 1 after the slot-0 load -> slot 0 values unchanged; slot 1 reads 2.0 everywhere; reg_m_size_out=2 for addr 1.
- m=0 or m=5 (>M) with load_en_in -> error pulse 1 cycle, no ack, slot contents unchanged.
- load_en_in pulsed again mid-load -> ignored; the first load completes with the correct data and a single ack.
- rst asserted after 2 of 4 elements -> all outputs 0, no ack, slot reads 0, next load works normally.
- Read (addr 0, i=3, j=3) after a 2x2 load -> data 0, complete 0.
